// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment display path
// (scan controller, digit decoder top, hex-to-segment converter).
package ssd_pkg;
  localparam int DIGIT_COUNT = 4;
  localparam int SEL_W       = 2;
  localparam int NIBBLE_W    = 4;
  localparam int VALUE_W     = 16;

  typedef logic [SEL_W-1:0]    sel_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [VALUE_W-1:0]  value_t;

  function automatic nibble_t digit_of(value_t v, sel_t s);
    return v[s*NIBBLE_W +: NIBBLE_W];
  endfunction
endpackage

// File: rtl/ssd_prescaler.sv
// Free-running divider: tick is high for one cycle out of every SCAN_DIV.
module ssd_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign tick = (cnt_reg == LAST);
endmodule

// File: rtl/ssd_scan_controller.sv
// Scans a shadow-buffered 16-bit hex value across four digits, with
// leading-zero blanking and per-digit decimal points.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VALUE_W-1:0]  value,
  input  logic                load,
  input  logic [DIGIT_COUNT-1:0] dp_in,
  input  logic                lz_blank,
  output logic [SEL_W-1:0]    sel,
  output logic [NIBBLE_W-1:0] nibble,
  output logic                digit_en,
  output logic                dp,
  output logic                frame_done
);
  logic                   tick;
  logic                   boundary;
  sel_t                   sel_reg;
  value_t                 disp_reg;
  value_t                 pend_reg;
  logic [DIGIT_COUNT-1:0] disp_dp_reg;
  logic [DIGIT_COUNT-1:0] pend_dp_reg;
  logic                   pend_flag_reg;
  logic                   frame_done_reg;
  logic [DIGIT_COUNT-1:0] upper_zero;

  ssd_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign boundary = tick && (sel_reg == sel_t'(DIGIT_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg        <= '0;
      disp_reg       <= '0;
      disp_dp_reg    <= '0;
      pend_reg       <= '0;
      pend_dp_reg    <= '0;
      pend_flag_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= boundary;
      if (tick) begin
        sel_reg <= sel_reg + sel_t'(1);
      end
      if (boundary) begin
        // A load landing on the boundary bypasses the older pending value.
        if (load) begin
          disp_reg    <= value;
          disp_dp_reg <= dp_in;
        end else if (pend_flag_reg) begin
          disp_reg    <= pend_reg;
          disp_dp_reg <= pend_dp_reg;
        end
        pend_flag_reg <= 1'b0;
      end else if (load) begin
        pend_reg      <= value;
        pend_dp_reg   <= dp_in;
        pend_flag_reg <= 1'b1;
      end
    end
  end

  // upper_zero[i]: display digits i..3 are all zero.
  for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_upper_zero
    assign upper_zero[gi] = (disp_reg[VALUE_W-1:gi*NIBBLE_W] == '0);
  end

  assign sel        = sel_reg;
  assign nibble     = digit_of(disp_reg, sel_reg);
  assign digit_en   = !(lz_blank && (sel_reg != '0) && upper_zero[sel_reg]);
  assign dp         = disp_dp_reg[sel_reg] && digit_en;
  assign frame_done = frame_done_reg;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with SCAN_DIV=4 (16-cycle frames).
module tb_ssd_scan_controller;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [1:0]  sel;
  logic [3:0]  nibble;
  logic        digit_en;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;  // edges since last reset release

  ssd_scan_controller #(.SCAN_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .sel        (sel),
    .nibble     (nibble),
    .digit_en   (digit_en),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz;
    logic [15:0] exp_nib;  // nibble expected at sel i in bits [4i+3:4i]
    logic [3:0]  exp_en;   // bit i = digit_en at sel i
    logic [3:0]  exp_dp;   // bit i = dp at sel i
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until the frame position (sel*DIV + prescale count) equals pos.
  task automatic goto_pos(input int pos);
    while ((cyc % (4 * DIV)) != pos) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  function automatic logic [3:0] nib_at(input logic [15:0] packed_nibs, input int i);
    return packed_nibs[i*4 +: 4];
  endfunction

  logic [15:0] prev_nib;

  initial begin
    vecs[0] = '{16'h1A2F, 4'b0000, 1'b0, 16'h1A2F, 4'b1111, 4'b0000};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, 16'h0005, 4'b0001, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 4'b0001, 4'b0000};
    vecs[3] = '{16'h0005, 4'b0000, 1'b0, 16'h0005, 4'b1111, 4'b0000};
    vecs[4] = '{16'h0040, 4'b0110, 1'b1, 16'h0040, 4'b0011, 4'b0010};
    vecs[5] = '{16'h8000, 4'b1000, 1'b1, 16'h8000, 4'b1111, 4'b1000};

    rst = 1'b1; value = '0; load = 1'b0; dp_in = '0; lz_blank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_nibble", 32'(nibble), 0);
    chk("rst_digit_en", 32'(digit_en), 1);
    chk("rst_dp", 32'(dp), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    rst = 1'b0;
    cyc = 0;

    // Free-running scan: sel advances every DIV cycles, frame_done on wrap.
    for (int c = 1; c <= 32; c++) begin
      step();
      chk("scan_sel", 32'(sel), 32'((c / DIV) % 4));
      chk("scan_frame_done", 32'(frame_done), 32'((c % 16 == 0) ? 1 : 0));
      if (sel == 2'd0) begin
        chk("scan_nibble", 32'(nibble), 0);
        chk("scan_digit_en", 32'(digit_en), 1);
      end
    end
    $display("scan: 32 cycles, checks=%0d errors=%0d", checks, errors);

    prev_nib = 16'h0000;
    for (int v = 0; v < 6; v++) begin
      goto_pos(DIV);  // sel=1, mid-frame
      lz_blank = vecs[v].lz;
      do_load(vecs[v].value, vecs[v].dp_in);
      goto_pos(2 * DIV);
      chk("shadow_sel2", 32'(nibble), 32'(nib_at(prev_nib, 2)));
      goto_pos(3 * DIV);
      chk("shadow_sel3", 32'(nibble), 32'(nib_at(prev_nib, 3)));
      goto_pos(0);
      chk("vec_frame_done", 32'(frame_done), 1);
      for (int s = 0; s < 4; s++) begin
        goto_pos(s * DIV);
        chk("vec_sel", 32'(sel), 32'(s));
        chk("vec_nibble", 32'(nibble), 32'(nib_at(vecs[v].exp_nib, s)));
        chk("vec_digit_en", 32'(digit_en), 32'(vecs[v].exp_en[s]));
        chk("vec_dp", 32'(dp), 32'(vecs[v].exp_dp[s]));
      end
      $display("vec %0d value=%h dp_in=%b lz=%b checks=%0d errors=%0d",
               v, vecs[v].value, vecs[v].dp_in, vecs[v].lz, checks, errors);
      prev_nib = vecs[v].exp_nib;
    end

    // Load coinciding with the frame boundary bypasses the pending value.
    lz_blank = 1'b0;
    goto_pos(DIV);
    do_load(16'h1111, 4'b0000);
    goto_pos(4 * DIV - 1);  // next edge is the sel==3 tick
    do_load(16'h2222, 4'b0000);
    chk("bypass_frame_done", 32'(frame_done), 1);
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        goto_pos(s * DIV);
        chk("bypass_nibble", 32'(nibble), 32'h2);
      end
      goto_pos(3 * DIV + 1);
    end
    $display("bypass: pending=1111 boundary_load=2222 checks=%0d errors=%0d", checks, errors);

    // Reset mid-frame with data pending: pending must be discarded.
    goto_pos(DIV);
    do_load(16'h3333, 4'b1111);
    goto_pos(2 * DIV);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_nibble", 32'(nibble), 0);
    chk("midrst_dp", 32'(dp), 0);
    chk("midrst_frame_done", 32'(frame_done), 0);
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        goto_pos(s * DIV + 1);
        chk("midrst_sel_run", 32'(sel), 32'(s));
        chk("midrst_nibble_run", 32'(nibble), 0);
        chk("midrst_dp_run", 32'(dp), 0);
      end
      goto_pos(3 * DIV + 2);
    end
    $display("midrst: pending=3333 discarded checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
